// File: rtl/pds_pkg.sv
// Shared types and default constants for the PDS per-port power sequencer.
package pds_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        INRUSH = 2'd1,
        ON     = 2'd2,
        FAULT  = 2'd3
    } port_state_t;

    localparam int unsigned NUM_PORTS_DEF  = 8;
    localparam int unsigned INRUSH_CYC_DEF = 16;
    localparam int unsigned OC_FILT_DEF    = 4;

endpackage

// File: rtl/pds_port_fsm.sv
// One port's power sequencer: state register, inrush window counter and
// overcurrent filter. The inrush slot is granted externally.
module pds_port_fsm
    import pds_pkg::*;
#(
    parameter int unsigned INRUSH_CYC = INRUSH_CYC_DEF,
    parameter int unsigned OC_FILT    = OC_FILT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic gnt,
    input  logic pg,
    input  logic oc,
    input  logic fault_clr,
    input  logic slot_gnt,
    output logic slot_req,
    output logic in_inrush,
    output logic pwr_en,
    output logic on,
    output logic fault
);

    localparam int unsigned ICW = $clog2(INRUSH_CYC + 1);
    localparam int unsigned OCW = $clog2(OC_FILT + 1);
    localparam logic [ICW-1:0] INRUSH_LAST = ICW'(INRUSH_CYC - 1);
    localparam logic [OCW-1:0] OC_LAST     = OCW'(OC_FILT - 1);
    localparam logic [OCW-1:0] OC_SAT      = OCW'(OC_FILT);

    port_state_t     state;
    logic [ICW-1:0]  icnt;
    logic [OCW-1:0]  ocnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= OFF;
            icnt  <= '0;
            ocnt  <= '0;
        end else begin
            case (state)
                OFF: begin
                    if (slot_gnt) begin
                        state <= INRUSH;
                        icnt  <= '0;
                    end
                end
                INRUSH: begin
                    if (!gnt) begin
                        state <= OFF;
                    end else if (icnt == INRUSH_LAST) begin
                        state <= pg ? ON : FAULT;
                        ocnt  <= '0;
                    end else begin
                        icnt <= icnt + ICW'(1);
                    end
                end
                ON: begin
                    // grant removal outranks both pg loss and an OC trip
                    if (!gnt) begin
                        state <= OFF;
                    end else if (!pg) begin
                        state <= FAULT;
                    end else if (oc) begin
                        if (ocnt == OC_LAST) begin
                            state <= FAULT;
                            ocnt  <= OC_SAT;
                        end else begin
                            ocnt <= ocnt + OCW'(1);
                        end
                    end else begin
                        ocnt <= '0;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        state <= OFF;
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

    assign slot_req  = (state == OFF) && gnt;
    assign in_inrush = (state == INRUSH);
    assign pwr_en    = (state == INRUSH) || (state == ON);
    assign on        = (state == ON);
    assign fault     = (state == FAULT);

endmodule

// File: rtl/pds_port_seq.sv
// Per-port power sequencer: one FSM per port, a single shared inrush slot
// given to the lowest-index requester whenever no port is ramping.
module pds_port_seq
    import pds_pkg::*;
#(
    parameter int unsigned numPorts   = NUM_PORTS_DEF,
    parameter int unsigned INRUSH_CYC = INRUSH_CYC_DEF,
    parameter int unsigned OC_FILT    = OC_FILT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [numPorts-1:0] gnt,
    input  logic [numPorts-1:0] pg,
    input  logic [numPorts-1:0] oc,
    input  logic [numPorts-1:0] fault_clr,
    output logic [numPorts-1:0] pwr_en,
    output logic [numPorts-1:0] on,
    output logic [numPorts-1:0] fault,
    output logic                inrush_busy
);

    logic [numPorts-1:0] slot_req;
    logic [numPorts-1:0] slot_gnt;
    logic [numPorts-1:0] in_inrush;

    for (genvar i = 0; i < numPorts; i++) begin : g_port
        pds_port_fsm #(
            .INRUSH_CYC (INRUSH_CYC),
            .OC_FILT    (OC_FILT)
        ) u_fsm (
            .clk       (clk),
            .reset_n   (reset_n),
            .gnt       (gnt[i]),
            .pg        (pg[i]),
            .oc        (oc[i]),
            .fault_clr (fault_clr[i]),
            .slot_gnt  (slot_gnt[i]),
            .slot_req  (slot_req[i]),
            .in_inrush (in_inrush[i]),
            .pwr_en    (pwr_en[i]),
            .on        (on[i]),
            .fault     (fault[i])
        );
    end

    assign inrush_busy = |in_inrush;

    always_comb begin
        logic found;
        found    = 1'b0;
        slot_gnt = '0;
        if (!inrush_busy) begin
            for (int unsigned i = 0; i < numPorts; i++) begin
                if (slot_req[i] && !found) begin
                    slot_gnt[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pds_port_seq.sv
// Bench for pds_port_seq: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_pds_port_seq;

    localparam int N  = 8;
    localparam int IC = 16;
    localparam int OF = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] gnt = '0;
    logic [N-1:0] pg = '1;
    logic [N-1:0] oc = '0;
    logic [N-1:0] fault_clr = '0;
    logic [N-1:0] pwr_en;
    logic [N-1:0] on;
    logic [N-1:0] fault;
    logic         inrush_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pds_port_seq #(
        .numPorts   (N),
        .INRUSH_CYC (IC),
        .OC_FILT    (OF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .gnt         (gnt),
        .pg          (pg),
        .oc          (oc),
        .fault_clr   (fault_clr),
        .pwr_en      (pwr_en),
        .on          (on),
        .fault       (fault),
        .inrush_busy (inrush_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each port is ramping (cycles left), powered, faulted or idle.
    int ramp_left[N];
    bit powered[N];
    bit faulted[N];
    int oc_run[N];
    bit model_on = 1'b0;

    task automatic model_step();
        int win;
        bit busy;
        win  = -1;
        busy = 1'b0;
        if (!reset_n) begin
            for (int p = 0; p < N; p++) begin
                ramp_left[p] = 0;
                powered[p]   = 1'b0;
                faulted[p]   = 1'b0;
                oc_run[p]    = 0;
            end
            model_on = 1'b1;
            return;
        end
        for (int p = 0; p < N; p++)
            if (ramp_left[p] > 0) busy = 1'b1;
        if (!busy)
            for (int p = 0; p < N; p++)
                if (win < 0 && gnt[p] && !faulted[p] && ramp_left[p] == 0 && !powered[p])
                    win = p;
        for (int p = 0; p < N; p++) begin
            if (faulted[p]) begin
                if (fault_clr[p]) faulted[p] = 1'b0;
            end else if (ramp_left[p] > 0) begin
                if (!gnt[p]) ramp_left[p] = 0;
                else if (ramp_left[p] == 1) begin
                    ramp_left[p] = 0;
                    if (pg[p]) begin
                        powered[p] = 1'b1;
                        oc_run[p]  = 0;
                    end else faulted[p] = 1'b1;
                end else ramp_left[p]--;
            end else if (powered[p]) begin
                if (!gnt[p]) powered[p] = 1'b0;
                else if (!pg[p]) begin
                    powered[p] = 1'b0;
                    faulted[p] = 1'b1;
                end else if (oc[p]) begin
                    oc_run[p]++;
                    if (oc_run[p] >= OF) begin
                        powered[p] = 1'b0;
                        faulted[p] = 1'b1;
                    end
                end else oc_run[p] = 0;
            end
        end
        if (win >= 0) ramp_left[win] = IC;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        logic [N-1:0] e_pwr, e_on, e_flt;
        logic         e_busy;
        if (model_on) begin
            e_busy = 1'b0;
            for (int p = 0; p < N; p++) begin
                e_pwr[p] = (ramp_left[p] > 0) || powered[p];
                e_on[p]  = powered[p];
                e_flt[p] = faulted[p];
                if (ramp_left[p] > 0) e_busy = 1'b1;
            end
            chk("pwr_en", 32'(pwr_en), 32'(e_pwr));
            chk("on", 32'(on), 32'(e_on));
            chk("fault", 32'(fault), 32'(e_flt));
            chk("inrush_busy", 32'(inrush_busy), 32'(e_busy));
            chk("single_ramp", 32'($countones(pwr_en & ~on) <= 1), 32'd1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        gnt       = '0;
        oc        = '0;
        fault_clr = '0;
        pg        = '1;
        cycles(1);
        reset_n = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        int rise[4];

        cycles(1);
        reset_n = 1'b1;

        // reset while a port is on
        gnt = 8'h01;
        cycles(20);
        chk("pre_reset_on", 32'(on), 32'h01);
        reset_n = 1'b0;
        cycles(1);
        chk("rst_pwr_en", 32'(pwr_en), 32'h0);
        chk("rst_on", 32'(on), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_busy", 32'(inrush_busy), 32'h0);

        // single port latency and busy width
        do_reset();
        gnt = 8'h04;
        cycles(1);
        chk("single_pwr_en", 32'(pwr_en), 32'h04);
        busy_cnt = inrush_busy ? 1 : 0;
        repeat (16) begin
            @(negedge clk);
            if (inrush_busy) busy_cnt++;
        end
        chk("single_on", 32'(on), 32'h04);
        chk("single_busy_len", 32'(busy_cnt), 32'd16);

        // stagger of four ports
        do_reset();
        gnt = 8'h0F;
        for (int k = 0; k < 4; k++) rise[k] = -1;
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (rise[k] < 0 && pwr_en[k]) rise[k] = t;
        end
        for (int k = 0; k < 4; k++) chk($sformatf("stagger_rise%0d", k), 32'(rise[k]), 32'(1 + 17 * k));

        // OC filter on port 3
        do_reset();
        gnt = 8'h08;
        cycles(18);
        chk("oc_on", 32'(on), 32'h08);
        oc[3] = 1'b1;
        cycles(3);
        oc = '0;
        cycles(2);
        chk("oc3_no_fault", 32'(fault), 32'h0);
        oc[3] = 1'b1;
        cycles(4);
        chk("oc4_fault", 32'(fault[3]), 32'd1);
        chk("oc4_pwr_off", 32'(pwr_en[3]), 32'd0);
        oc  = '0;
        gnt = '0;
        cycles(2);
        chk("oc_fault_hold", 32'(fault[3]), 32'd1);
        fault_clr[3] = 1'b1;
        cycles(1);
        fault_clr = '0;
        chk("oc_clr", 32'(fault), 32'h0);

        // pg loss on last inrush cycle of port 1
        do_reset();
        gnt = 8'h02;
        cycles(16);
        pg[1] = 1'b0;
        cycles(1);
        chk("pg_fault", 32'(fault[1]), 32'd1);
        chk("pg_no_on", 32'(on[1]), 32'd0);
        pg = '1;
        cycles(3);
        chk("pg_still_off", 32'(on[1]), 32'd0);
        fault_clr[1] = 1'b1;
        cycles(1);
        fault_clr = '0;
        chk("pg_clr_off", 32'(pwr_en[1]), 32'd0);
        cycles(1);
        chk("pg_reramp", 32'(pwr_en[1]), 32'd1);

        // grant drop coinciding with the trip cycle, then stray clears
        do_reset();
        gnt = 8'h20;
        cycles(18);
        oc[5] = 1'b1;
        cycles(3);
        gnt[5] = 1'b0;
        cycles(1);
        chk("simul_no_fault", 32'(fault[5]), 32'd0);
        chk("simul_off", 32'(pwr_en[5]), 32'd0);
        oc  = '0;
        gnt = 8'h20;
        cycles(18);
        fault_clr = '1;
        cycles(1);
        fault_clr = '0;
        chk("stray_clr_on", 32'(on), 32'h20);
        chk("stray_clr_fault", 32'(fault), 32'h0);

        // reset mid-inrush
        do_reset();
        gnt = 8'h01;
        cycles(5);
        reset_n = 1'b0;
        cycles(1);
        chk("rst_inrush_pwr", 32'(pwr_en), 32'h0);
        reset_n = 1'b1;
        gnt = '0;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(99) < 8) gnt[p] = ~gnt[p];
                pg[p]        = ($urandom_range(99) < 97);
                oc[p]        = ($urandom_range(99) < 15);
                fault_clr[p] = ($urandom_range(99) < 5);
            end
            reset_n = ($urandom_range(999) >= 3);
            cycles(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
